// File: rtl/regfile_read_queue.sv
// Operand-read queue for the 32x64 register file: captures both source operands
// at request time, keeps buffered operands coherent with writes, and issues in FIFO order.
module regfile_read_queue #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned TAGW  = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       softReset,
    input  logic [31:0][63:0]          regValues,
    input  logic [31:0]                wrEnable,
    input  logic [63:0]                wrData,
    input  logic                       reqValid,
    output logic                       reqReady,
    input  logic [4:0]                 reqRs1,
    input  logic [4:0]                 reqRs2,
    input  logic [TAGW-1:0]            reqTag,
    output logic                       outValid,
    input  logic                       outReady,
    output logic [63:0]                outOp1,
    output logic [63:0]                outOp2,
    output logic [TAGW-1:0]            outTag,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [4:0]  ZERO_REG = 5'd31;

    logic [63:0]     op1_q [DEPTH];
    logic [63:0]     op1_d [DEPTH];
    logic [63:0]     op2_q [DEPTH];
    logic [63:0]     op2_d [DEPTH];
    logic [4:0]      rs1_q [DEPTH];
    logic [4:0]      rs1_d [DEPTH];
    logic [4:0]      rs2_q [DEPTH];
    logic [4:0]      rs2_d [DEPTH];
    logic [TAGW-1:0] tag_q [DEPTH];
    logic [TAGW-1:0] tag_d [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic        push, pop;
    logic [63:0] cap1, cap2;

    assign outValid = (count_q != '0);
    assign pop      = outValid & outReady;
    assign reqReady = (count_q < CW'(DEPTH)) | pop;
    assign push     = reqValid & reqReady;
    assign count    = count_q;

    assign outOp1 = outValid ? op1_q[rd_ptr_q] : 64'd0;
    assign outOp2 = outValid ? op2_q[rd_ptr_q] : 64'd0;
    assign outTag = outValid ? tag_q[rd_ptr_q] : '0;

    // Operand capture with same-cycle write bypass; the zero register ignores writes.
    always_comb begin
        cap1 = 64'd0;
        cap2 = 64'd0;
        if (reqRs1 != ZERO_REG) begin
            cap1 = wrEnable[reqRs1] ? wrData : regValues[reqRs1];
        end
        if (reqRs2 != ZERO_REG) begin
            cap2 = wrEnable[reqRs2] ? wrData : regValues[reqRs2];
        end
    end

    // Entry snoop, push write and pointer/count next state.
    always_comb begin
        op1_d    = op1_q;
        op2_d    = op2_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        tag_d    = tag_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        // Invalid entries snoop too; their contents are never observed.
        for (int i = 0; i < DEPTH; i++) begin
            if (rs1_q[i] != ZERO_REG && wrEnable[rs1_q[i]]) begin
                op1_d[i] = wrData;
            end
            if (rs2_q[i] != ZERO_REG && wrEnable[rs2_q[i]]) begin
                op2_d[i] = wrData;
            end
        end

        if (push) begin
            op1_d[wr_ptr_q] = cap1;
            op2_d[wr_ptr_q] = cap2;
            rs1_d[wr_ptr_q] = reqRs1;
            rs2_d[wr_ptr_q] = reqRs2;
            tag_d[wr_ptr_q] = reqTag;
            wr_ptr_d        = PW'(wr_ptr_q + PW'(1));
        end
        if (pop) begin
            rd_ptr_d = PW'(rd_ptr_q + PW'(1));
        end

        case ({push, pop})
            2'b10:   count_d = CW'(count_q + CW'(1));
            2'b01:   count_d = CW'(count_q - CW'(1));
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || softReset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
        op1_q <= op1_d;
        op2_q <= op2_d;
        rs1_q <= rs1_d;
        rs2_q <= rs2_d;
        tag_q <= tag_d;
    end

endmodule

// File: tb/tb_regfile_read_queue.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based reference model.
module tb_regfile_read_queue;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned TAGW  = 6;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic                 clk = 1'b0;
    logic                 reset, softReset;
    logic [31:0][63:0]    regValues;
    logic [31:0]          wrEnable;
    logic [63:0]          wrData;
    logic                 reqValid, reqReady;
    logic [4:0]           reqRs1, reqRs2;
    logic [TAGW-1:0]      reqTag;
    logic                 outValid, outReady;
    logic [63:0]          outOp1, outOp2;
    logic [TAGW-1:0]      outTag;
    logic [CW-1:0]        count;

    regfile_read_queue #(.DEPTH(DEPTH), .TAGW(TAGW)) dut (
        .clk(clk), .reset(reset), .softReset(softReset),
        .regValues(regValues), .wrEnable(wrEnable), .wrData(wrData),
        .reqValid(reqValid), .reqReady(reqReady),
        .reqRs1(reqRs1), .reqRs2(reqRs2), .reqTag(reqTag),
        .outValid(outValid), .outReady(outReady),
        .outOp1(outOp1), .outOp2(outOp2), .outTag(outTag),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [63:0]     op1;
        logic [63:0]     op2;
        logic [TAGW-1:0] tag;
    } ent_t;

    ent_t mq[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] read_reg(input logic [4:0] rs);
        if (rs == 5'd31) return 64'd0;
        if (wrEnable[rs]) return wrData;
        return regValues[rs];
    endfunction

    // Compare DUT against the model, clock once, then advance the model.
    task automatic step();
        logic   exp_valid, exp_ready, do_pop, do_push;
        ent_t   e;
        #1;
        exp_valid = (mq.size() != 0);
        exp_ready = (mq.size() < DEPTH) || (exp_valid && outReady);
        check_eq("outValid", 64'(outValid), 64'(exp_valid));
        check_eq("reqReady", 64'(reqReady), 64'(exp_ready));
        check_eq("count",    64'(count),    64'(mq.size()));
        check_eq("outOp1",   outOp1, exp_valid ? mq[0].op1 : 64'd0);
        check_eq("outOp2",   outOp2, exp_valid ? mq[0].op2 : 64'd0);
        check_eq("outTag",   64'(outTag), exp_valid ? 64'(mq[0].tag) : 64'd0);
        @(posedge clk);
        if (reset || softReset) begin
            mq.delete();
        end else begin
            do_pop  = exp_valid && outReady;
            do_push = reqValid && exp_ready;
            foreach (mq[i]) begin
                if (mq[i].rs1 != 5'd31 && wrEnable[mq[i].rs1]) mq[i].op1 = wrData;
                if (mq[i].rs2 != 5'd31 && wrEnable[mq[i].rs2]) mq[i].op2 = wrData;
            end
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                e.rs1 = reqRs1;
                e.rs2 = reqRs2;
                e.op1 = read_reg(reqRs1);
                e.op2 = read_reg(reqRs2);
                e.tag = reqTag;
                mq.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic push_req(input logic [4:0] r1, input logic [4:0] r2, input logic [TAGW-1:0] t);
        reqValid = 1'b1;
        reqRs1   = r1;
        reqRs2   = r2;
        reqTag   = t;
    endtask

    function automatic logic [4:0] rand_reg();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r >= 8) return 5'd31;
        return 5'(r);
    endfunction

    initial begin
        reset = 1'b1; softReset = 1'b0; regValues = '0; wrEnable = '0; wrData = '0;
        reqValid = 1'b0; reqRs1 = '0; reqRs2 = '0; reqTag = '0; outReady = 1'b0;
        @(negedge clk);
        step();
        reset = 1'b0;
        check_eq("reset_count", 64'(count), 64'd0);
        check_eq("reset_valid", 64'(outValid), 64'd0);

        // Basic read of two registers.
        regValues[3] = 64'hA; regValues[7] = 64'hB; outReady = 1'b1;
        push_req(5'd3, 5'd7, 6'd5);
        step();
        reqValid = 1'b0;
        check_eq("basic_op1", outOp1, 64'hA);
        check_eq("basic_op2", outOp2, 64'hB);
        check_eq("basic_tag", 64'(outTag), 64'd5);
        step();
        check_eq("basic_drain", 64'(count), 64'd0);

        // Zero register ignores storage contents and writes.
        regValues[31] = 64'hFFFF; wrEnable = 32'h8000_0000; wrData = 64'h1234;
        push_req(5'd31, 5'd31, 6'd1);
        step();
        reqValid = 1'b0; wrEnable = '0;
        check_eq("zero_op1", outOp1, 64'd0);
        check_eq("zero_op2", outOp2, 64'd0);
        step();

        // Same-cycle write bypass.
        regValues[4] = 64'd1; wrEnable = 32'h10; wrData = 64'h99;
        push_req(5'd4, 5'd3, 6'd2);
        step();
        reqValid = 1'b0; wrEnable = '0;
        check_eq("bypass_op1", outOp1, 64'h99);
        step();

        // Stalled head snoops a later write.
        outReady = 1'b0; regValues[9] = 64'd2;
        push_req(5'd3, 5'd9, 6'd3);
        step();
        reqValid = 1'b0;
        step();
        step();
        wrEnable = 32'h200; wrData = 64'h77;
        step();
        wrEnable = '0;
        check_eq("stall_op2", outOp2, 64'h77);
        outReady = 1'b1;
        step();
        outReady = 1'b0;

        // Fill, backpressure and pointer wrap.
        push_req(5'd1, 5'd2, 6'd0); step();
        push_req(5'd1, 5'd2, 6'd1); step();
        push_req(5'd1, 5'd2, 6'd2); step();
        check_eq("full_count", 64'(count), 64'(DEPTH));
        check_eq("full_head",  64'(outTag), 64'd0);
        outReady = 1'b1;
        step();
        reqValid = 1'b0;
        check_eq("wrap_head1", 64'(outTag), 64'd1);
        step();
        check_eq("wrap_head2", 64'(outTag), 64'd2);
        step();

        // Flush while full with a competing request.
        outReady = 1'b0;
        push_req(5'd3, 5'd7, 6'd10); step();
        push_req(5'd3, 5'd7, 6'd11); step();
        softReset = 1'b1;
        push_req(5'd3, 5'd7, 6'd12);
        step();
        softReset = 1'b0;
        reqValid = 1'b0;
        check_eq("flush_count", 64'(count), 64'd0);
        check_eq("flush_op1",   outOp1, 64'd0);
        push_req(5'd7, 5'd3, 6'd13);
        step();
        reqValid = 1'b0;
        check_eq("post_flush_tag", 64'(outTag), 64'd13);
        outReady = 1'b1;
        step();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            int unsigned w;
            reset     = ($urandom_range(0, 199) == 0);
            softReset = ($urandom_range(0, 99) == 0);
            for (int r = 0; r < 10; r++) regValues[r] = {$urandom(), $urandom()};
            regValues[31] = {$urandom(), $urandom()};
            wrData = {$urandom(), $urandom()};
            w = $urandom_range(0, 9);
            if (w < 5)      wrEnable = '0;
            else if (w < 9) wrEnable = 32'(1) << rand_reg();
            else            wrEnable = (32'(1) << rand_reg()) | (32'(1) << rand_reg());
            reqValid = $urandom_range(0, 1) == 1;
            reqRs1   = rand_reg();
            reqRs2   = rand_reg();
            reqTag   = TAGW'($urandom());
            outReady = $urandom_range(0, 9) < 6;
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/regfile_read_queue.md
Name: regfile_read_queue

Overview:
- Read-side companion to the 32x64 register file storage.
- Accepts operand-read requests of two source registers plus a tag, and captures both 64-bit operands from the storage outputs.
- Forwards same-cycle writes, keeps buffered operands coherent with later writes, and presents results through a valid/ready output queue to issue/execute.
- Register 31 is the zero register and always reads 0.

Parameters:
- DEPTH, 2, number of output queue entries (power of 2, ≥2).
- TAGW, 6, width of the request tag carried through unchanged.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high; clears all queue state.
- softReset  input  1  synchronous, active-high flush; same effect as reset on queue state.
- regValues  input  [31:0][63:0]  current storage contents; regValues[i] is register i.
- wrEnable  input  32  one-hot write enable presented to storage this cycle.
- wrData  input  64  write data presented to storage this cycle.
- reqValid  input  1  request present.
- reqReady  output  1  queue can accept a request.
- reqRs1  input  5  source register 1.
- reqRs2  input  5  source register 2.
- reqTag  input  TAGW  opaque tag.
- outValid  output  1  head entry valid.
- outReady  input  1  consumer accepts head.
- outOp1  output  64  head operand 1.
- outOp2  output  64  head operand 2.
- outTag  output  TAGW  head tag.
- count  output  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Interface: single clock clk; reset synchronous active-high. reset or softReset asserted at a posedge sets count=0, read/write pointers=0, and outValid=0 next cycle. Entry contents are don't-care but outOp1/outOp2/outTag must read 0 when outValid=0. reset/softReset override any same-cycle push or pop.
- Handshake:
  - push = reqValid & reqReady.
  - pop = outValid & outReady.
  - reqReady = (count < DEPTH) | pop, i.e. a full queue accepts when the head pops in the same cycle.
  - reqReady must not depend on reqValid.
- Latency: a request pushed at edge N is visible at the output after edge N, provided it becomes head. An empty queue presents it the cycle after acceptance. There is no combinational request-to-output path.
- Operand capture at push, per source rs:
  - rs==31 → 0.
  - else if wrEnable[rs] → wrData (same-cycle bypass; storage has not yet updated).
  - else → regValues[rs].
- Coherency: every valid entry snoops writes each cycle. For each operand with rs≠31 and wrEnable[rs]=1, the stored value is replaced with wrData at that edge. This includes the head while it stalls (outReady=0). The entry being popped that cycle need not update.
- wrEnable[31] is ignored for both capture and snoop.
- wrEnable is expected one-hot or zero. If multiple bits are set, each matching register gets wrData, consistent with storage.
- rs1==rs2 is legal; both operands follow the same rules.
- Queue:
  - Circular buffer; pointers wrap modulo DEPTH.
  - count increments on push only, decrements on pop only, and is unchanged on simultaneous push and pop.
  - outValid = (count != 0).
  - Output order is strict FIFO.
  - Empty with simultaneous push: no pop is possible that cycle (outValid=0).
- Outputs come from registers or the head-select mux only; none depend combinationally on reqValid or outReady except reqReady.

Test Plan:
- Reset, then regValues[3]=64'hA, regValues[7]=64'hB; push rs1=3, rs2=7, tag=5 with outReady=1 → next cycle outValid=1, outOp1=A, outOp2=B, outTag=5; following cycle outValid=0, count=0.
- Push rs1=31, rs2=31 while regValues[31]=64'hFFFF and wrEnable[31]=1 → outOp1=outOp2=0.
- Same-cycle bypass: push rs1=4 with regValues[4]=1, wrEnable=32'h10, wrData=64'h99 → outOp1=64'h99.
- Stall coherency: outReady=0, head holds rs2=9 (value 2); two cycles later pulse wrEnable[9] with wrData=64'h77 → outOp2 becomes 64'h77 the next cycle; raise outReady → popped with 77.
- Fill/backpressure: outReady=0, push 3 requests with DEPTH=2 → third held (reqReady=0), count=2. Assert outReady → third accepted the same cycle as the head pops; tags emerge in order 0,1,2 through pointer wrap.
- Mid-operation flush: queue full, softReset=1 for one cycle with reqValid=1 → next cycle count=0, outValid=0, outputs 0; a subsequent push is accepted normally.
